// File: rtl/mem_responder.sv
// Memory-side responder: MAR/MDR registers, word-addressed RAM and a
// wait-state handshake that raises MFC a fixed number of cycles after a request.
module mem_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MAR_EN,
  input  logic              MDR_EN_write,
  input  logic              MDR_EN_read,
  input  logic              MDR_out,
  input  logic              mem_EN,
  input  logic              mem_RW,
  output logic              MFC,
  output logic              busy,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [DATA_W-1:0]   rd_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                op_q, op_d;
  logic                ram_we;
  logic                ram_re;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;

    if (MAR_EN) begin
      mar_d = bus_in;
    end
    if (MDR_EN_read) begin
      mdr_d = rd_q;
    end else if (MDR_EN_write) begin
      mdr_d = bus_in;
    end

    case (state_q)
      S_IDLE: begin
        // Latch the request from pre-edge register values so later MAR/MDR
        // traffic cannot disturb the access in flight.
        if (mem_EN) begin
          addr_d  = mar_q[ADDR_W-1:0];
          wdata_d = mdr_q;
          op_d    = mem_RW;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mem_EN) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_ACK;
          if (op_q) begin
            ram_re = 1'b1;
          end else begin
            ram_we = 1'b1;
          end
        end
      end
      S_ACK: begin
        if (!mem_EN) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (ram_re) begin
      rd_q <= mem_q[addr_q];
    end
  end

  // RAM contents survive reset; a reset edge suppresses an uncommitted write.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  generate
    if (ADDR_W < DATA_W) begin : g_mar_hi
      logic unused_mar_hi;
      assign unused_mar_hi = ^mar_q[DATA_W-1:ADDR_W];
    end
  endgenerate

  assign MFC       = (state_q == S_ACK);
  assign busy      = (state_q == S_WAIT);
  assign bus_drive = MDR_out;
  assign bus_out   = MDR_out ? mdr_q : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: four instances at latencies 2, 1, 15 and 3
// share the register strobes; each has its own mem_EN and MDR_out.
module tb_mem_responder;

  localparam int NI = 4;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      2:       return 15;
      default: return 3;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_in = '0;
  logic        mar_en = 1'b0;
  logic        mdr_wr = 1'b0;
  logic        mdr_rd = 1'b0;
  logic        mem_rw = 1'b0;
  logic        mem_en  [NI];
  logic        mdr_out [NI];
  logic        mfc     [NI];
  logic        busy    [NI];
  logic        drv     [NI];
  logic [15:0] bout    [NI];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  int          mfc_q  [NI][$];
  int          mlen_q [NI][$];
  int          busy_q [NI][$];
  logic [15:0] dat_q  [NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_responder #(
        .DATA_W (16),
        .ADDR_W (8),
        .LATENCY(lat_of(g))
      ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus_in      (bus_in),
        .MAR_EN      (mar_en),
        .MDR_EN_write(mdr_wr),
        .MDR_EN_read (mdr_rd),
        .MDR_out     (mdr_out[g]),
        .mem_EN      (mem_en[g]),
        .mem_RW      (mem_rw),
        .MFC         (mfc[g]),
        .busy        (busy[g]),
        .bus_out     (bout[g]),
        .bus_drive   (drv[g])
      );
    end
  endgenerate

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[inst %0d]: got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents an event.
  logic mfc_p [NI];
  int   mcnt  [NI];
  int   bcnt  [NI];
  initial begin
    for (int k = 0; k < NI; k++) begin
      mfc_p[k] = 1'b0;
      mcnt[k]  = 0;
      bcnt[k]  = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < NI; k++) begin
        if (mfc[k] === 1'b1) begin
          if (!mfc_p[k]) begin
            if (mfc_q[k].size() == 0) check("mfc_unexpected", k, 32'(mfc[k]), 0);
            else check("mfc_rise_cycle", k, cyc, mfc_q[k].pop_front());
          end
          mcnt[k]++;
        end else if (mcnt[k] != 0) begin
          if (mlen_q[k].size() == 0) check("mfc_len_unexpected", k, mcnt[k], 0);
          else check("mfc_high_cycles", k, mcnt[k], mlen_q[k].pop_front());
          mcnt[k] = 0;
        end
        if (busy[k] === 1'b1) begin
          bcnt[k]++;
        end else if (bcnt[k] != 0) begin
          if (busy_q[k].size() == 0) check("busy_unexpected", k, bcnt[k], 0);
          else check("busy_cycles", k, bcnt[k], busy_q[k].pop_front());
          bcnt[k] = 0;
        end
        if (drv[k] === 1'b1) begin
          if (dat_q[k].size() == 0) check("bus_unexpected", k, 32'(bout[k]), 0);
          else check("bus_out", k, 32'(bout[k]), 32'(dat_q[k].pop_front()));
        end
        mfc_p[k] = (mfc[k] === 1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input logic [15:0] a);
    bus_in = a; mar_en = 1'b1; tick(); mar_en = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] d);
    bus_in = d; mdr_wr = 1'b1; tick(); mdr_wr = 1'b0;
  endtask

  task automatic show(input int k, input logic [15:0] exp);
    dat_q[k].push_back(exp);
    mdr_out[k] = 1'b1; tick(); mdr_out[k] = 1'b0;
  endtask

  // Full handshake; mem_RW toggles while holding to prove it is ignored in ACK.
  task automatic access(input int k, input logic rw, input int hold);
    bit got;
    mem_rw = rw;
    mem_en[k] = 1'b1;
    mfc_q[k].push_back(cyc + 1 + lat_of(k));
    busy_q[k].push_back(lat_of(k));
    mlen_q[k].push_back(1 + hold);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (mfc[k] === 1'b1) got = 1'b1;
    end
    if (!got) check("mfc_timeout", k, 32'(mfc[k]), 1);
    for (int i = 0; i < hold; i++) begin
      mem_rw = ~mem_rw;
      tick();
    end
    mem_en[k] = 1'b0;
    tick();
    tick();
  endtask

  task automatic write_word(input int k, input logic [15:0] a, input logic [15:0] d,
                            input int hold);
    load_mar(a);
    load_mdr(d);
    access(k, 1'b0, hold);
  endtask

  task automatic read_word(input int k, input logic [15:0] a, input bit use_mar,
                           input logic [15:0] exp);
    if (use_mar) load_mar(a);
    access(k, 1'b1, 0);
    mdr_rd = 1'b1; tick(); mdr_rd = 1'b0;
    show(k, exp);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      mem_en[k]  = 1'b0;
      mdr_out[k] = 1'b0;
    end
    tick();
    started = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset values: MDR and read-data register both zero.
    show(1, 16'h0000);
    mdr_rd = 1'b1; tick(); mdr_rd = 1'b0;
    show(2, 16'h0000);

    // Store then load at latency 2.
    write_word(0, 16'h0000, 16'h0A0A, 0);
    write_word(0, 16'h0005, 16'hBEEF, 0);
    read_word(0, 16'h0005, 1'b1, 16'hBEEF);

    // MDR_EN_read wins over MDR_EN_write.
    bus_in = 16'h5555; mdr_rd = 1'b1; mdr_wr = 1'b1; tick();
    mdr_rd = 1'b0; mdr_wr = 1'b0;
    show(0, 16'hBEEF);

    // Upper MAR bits alias onto the low address bits.
    write_word(0, 16'h0105, 16'h4242, 0);
    read_word(0, 16'h0005, 1'b1, 16'h4242);
    read_word(0, 16'h0305, 1'b1, 16'h4242);

    // Hold mem_EN 10 cycles past MFC: one access, later MDR change harmless.
    write_word(0, 16'h0020, 16'h7777, 10);
    load_mdr(16'h9999);
    read_word(0, 16'h0020, 1'b1, 16'h7777);

    // Latency extremes.
    write_word(1, 16'h0003, 16'h1111, 0);
    read_word(1, 16'h0003, 1'b1, 16'h1111);
    write_word(2, 16'h0004, 16'h2222, 0);
    read_word(2, 16'h0004, 1'b1, 16'h2222);

    // Abort after one WAIT cycle at latency 3: busy for 2 cycles, no MFC.
    write_word(3, 16'h0009, 16'hBEEF, 0);
    load_mar(16'h0009);
    load_mdr(16'h1234);
    mem_rw = 1'b0;
    mem_en[3] = 1'b1;
    busy_q[3].push_back(2);
    tick();
    tick();
    mem_en[3] = 1'b0;
    tick();
    tick();
    read_word(3, 16'h0009, 1'b1, 16'hBEEF);

    // Reset one cycle into WAIT of a write to addr 7.
    write_word(0, 16'h0007, 16'h0707, 0);
    load_mar(16'h0007);
    load_mdr(16'hDEAD);
    mem_rw = 1'b0;
    mem_en[0] = 1'b1;
    busy_q[0].push_back(1);
    tick();
    rst = 1'b1;
    mem_en[0] = 1'b0;
    tick();
    rst = 1'b0;
    show(0, 16'h0000);
    read_word(0, 16'h0000, 1'b0, 16'h0A0A);
    read_word(0, 16'h0007, 1'b1, 16'h0707);

    repeat (5) tick();
    for (int k = 0; k < NI; k++) begin
      check("pending_expectations", k,
            mfc_q[k].size() + mlen_q[k].size() + busy_q[k].size() + dat_q[k].size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d",
             errors, checks);
    $fatal(1);
  end

endmodule
